popcount_arbiter: RTL
=====================

Name: popcount_arbiter

Overview:
Shares one registered 64-bit population-count datapath between NREQ requesters, e.g. search cores needing disc counts or mobility counts for board evaluation. Round-robin arbitration, one request accepted per cycle, fixed 2-cycle latency to a per-requester result register held until the requester consumes it. Each requester has at most one request outstanding.

Parameters:
NREQ, 4, number of requesters (2..8); requester index width IW = $clog2(NREQ), minimum 1.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NREQ  request i presents an operand
req_ready  output  NREQ  request i accepted this cycle (one-hot or zero)
req_x  input  64*NREQ  operand of requester i in bits [64*i+63:64*i]
resp_valid  output  NREQ  result for requester i available
resp_ready  input  NREQ  requester i consumes its result
resp_count  output  7*NREQ  popcount result of requester i in bits [7*i+6:7*i], range 0..64

Behaviour:
- Reset (async assert, sync release): req_ready=0, resp_valid=0, resp_count=0, stage-1 valid=0, all busy flags=0, rr pointer=0.
- busy[i] = request i in flight (stage 1) OR resp_valid[i]. eligible[i] = req_valid[i] & ~busy[i].
- Grant: combinational; first eligible index searching ptr, ptr+1, ... wrapping mod NREQ. req_ready = one-hot of that index, zero if none eligible. Handshake = req_valid[i] & req_ready[i].
- req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready. req_valid/req_x held stable until handshake.
- Pointer: on a grant to index g, ptr <= (g+1) mod NREQ; unchanged if no grant.
- Stage 1 (cycle t = handshake cycle): operand and index IW bits registered; s1_valid <= 1 on grant else 0.
- Stage 2 (cycle t+1): 64-bit popcount of registered operand (tree of 8-bit counts, 7-bit sum) written to resp_count of stored index; resp_valid[idx] <= 1. resp_valid observed high from cycle t+2 (2-cycle latency, edge t to edge t+2).
- Throughput: one grant per cycle, pipeline never stalls; per-requester backpressure only via resp_valid hold.
- Response: resp_valid[i] and resp_count[i] held until resp_valid[i] & resp_ready[i]; then resp_valid[i] <= 0, resp_count[i] keeps its last value.
- Requester i becomes eligible again the cycle after its response handshake (no same-cycle re-grant); busy[i] during stage 1 and response hold.
- resp_ready[i] while resp_valid[i]=0: ignored.
- Stage-2 write and response handshake for different requesters in same cycle: independent. Same requester cannot collide (busy rule).
- Reset mid-operation: in-flight request and pending results discarded, outputs to reset values immediately; no response ever issued for discarded requests.
- Width: sum of eight 4-bit counts zero-extended to 7 bits; 64 must be representable (no truncation).

Test Plan:
- Single request, requester 0, req_x=64'hFFFF_FFFF_FFFF_FFFF, resp_ready=1 -> req_ready[0]=1 in cycle t, resp_valid[0] high at t+2, resp_count[0]=64, low at t+3.
- Requester 2, req_x=0, then 64'h8000_0000_0000_0001, then 64'h5555_5555_5555_5555 -> counts 0, 2, 32 in order, each at handshake+2.
- All four req_valid high at once after reset, resp_ready=1 -> grants 0,1,2,3 in consecutive cycles, responses in same order two cycles later; next round again starts after ptr wraps, no requester granted twice before others.
- resp_ready[1]=0 held 10 cycles with req_valid[1] kept high -> resp_valid[1] and count held, req_ready[1]=0 throughout, requesters 0,2,3 keep being granted; after resp_ready[1]=1, requester 1 re-granted no earlier than the following cycle.
- Random 64-bit operands, random valid/ready over 10k cycles -> every count matches reference popcount, one response per accepted request, per-requester order preserved, req_ready never multi-hot.
- Assert rst one cycle after grant to requester 3 -> resp_valid all 0 immediately, no response for requester 3 after release, ptr=0 so requester 0 wins first contested grant.

Source files
------------

// File: rtl/popcount_arbiter.sv
// rtl/popcount_arbiter.sv - round-robin shared 64-bit popcount pipe
// One grant per cycle, 2-cycle latency, per-requester result held until consumed.
module popcount_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [7*NREQ-1:0]    resp_count
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   s1_idx;
  logic [IW-1:0]   grant_idx;
  logic            s1_valid;
  logic            grant_any;
  logic [63:0]     s1_x;
  logic [63:0]     grant_x;
  logic [6:0]      s2_count;
  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] eligible;

  function automatic logic [3:0] count8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < 8; k++) c = c + {3'b000, b[k]};
    return c;
  endfunction

  function automatic logic [6:0] count64(input logic [63:0] x);
    logic [6:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) s = s + {3'b000, count8(x[8*b +: 8])};
    return s;
  endfunction

  // A requester stays busy from acceptance until its result is consumed.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      busy[i] = resp_valid[i] | (s1_valid && s1_idx == IW'(i));
    end
    eligible = req_valid & ~busy;
  end

  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!grant_any && eligible[j]) begin
        grant_any = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_comb begin
    grant_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_any && !rst && grant_idx == IW'(i);
      if (grant_idx == IW'(i)) grant_x = req_x[64*i +: 64];
    end
  end

  assign s2_count = count64(s1_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      s1_valid   <= 1'b0;
      s1_idx     <= '0;
      s1_x       <= '0;
      resp_valid <= '0;
      resp_count <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_idx <= grant_idx;
        s1_x   <= grant_x;
        ptr    <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
      end
      // Consume and stage-2 write never target the same requester.
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) resp_valid[i] <= 1'b0;
        if (s1_valid && s1_idx == IW'(i)) begin
          resp_valid[i]         <= 1'b1;
          resp_count[7*i +: 7] <= s2_count;
        end
      end
    end
  end
endmodule
